// File: rtl/sd_dat_block_rx.sv
// ---------------------------------------------------------------------------
// sd_dat_block_rx
//
// Receives one SD 4-bit data block from the card. The block drives sd_clk,
// waits for the start bit, assembles nibbles into 32-bit little-endian words,
// checks the end bit (and, optionally, the per-line CRC16), and queues the
// words in a FIFO that the CPU drains over an Avalon-MM slave port.
//
// Optional feature macro: SD_DAT_RX_CRC_EN
//   defined   - one CRC16-CCITT generator per DAT line; a CRC mismatch or a
//               bad end bit sets crc_err.
//   undefined - no CRC logic; the 16 CRC ticks are still consumed and only
//               a bad end bit sets crc_err.
//
// Parameters
//   CLK_DIV     half-period of sd_clk in clk cycles (>= 2)
//   FIFO_DEPTH  receive FIFO depth in 32-bit words (power of two)
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   address[1:0]        0 DATA, 1 CTRL/STATUS, 2 BLKLEN, 3 TIMEOUT
//   chipselect, read    read strobe; a DATA read pops the FIFO
//   write_n, writedata  active-low write strobe and data
//   readdata            registered read data (1 clk latency)
//   sd_clk              SD clock to the card, low while idle
//   dat_in[3:0]         SD DAT lines, asynchronous to clk
//   irq                 level interrupt, done & irq_en
// ---------------------------------------------------------------------------
module sd_dat_block_rx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sd_clk,
  input  logic [3:0]  dat_in,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END, S_DONE
  } state_t;

  // Bus decode
  logic wr_en, ctrl_wr, start_req, flush_req, pop_req;
  assign wr_en     = chipselect & ~write_n;
  assign ctrl_wr   = wr_en & (address == 2'd1);
  assign start_req = ctrl_wr & writedata[0];
  assign flush_req = ctrl_wr & writedata[2];
  assign pop_req   = chipselect & read & (address == 2'd0);

  logic unused_bits;
  assign unused_bits = ^writedata[31:24];

  // DAT synchronizer; idle lines are high
  logic [3:0] dat_s1_reg, dat_s2_reg;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dat_s1_reg <= 4'hF;
      dat_s2_reg <= 4'hF;
    end else begin
      dat_s1_reg <= dat_in;
      dat_s2_reg <= dat_s1_reg;
    end
  end

  state_t      state_reg;
  logic        busy_reg, done_reg, crc_err_reg, timeout_reg, overrun_reg, irq_en_reg;
  logic [11:0] blklen_cfg_reg;
  logic [23:0] timeout_cfg_reg;

  // sd_clk divider; the tick is the cycle whose edge drives sd_clk 0->1
  logic [DW-1:0] div_cnt_reg;
  logic          tick;
  assign tick = busy_reg & ~sd_clk & (div_cnt_reg == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_reg <= '0;
      sd_clk      <= 1'b0;
    end else if (!busy_reg) begin
      div_cnt_reg <= '0;
      sd_clk      <= 1'b0;
    end else if (div_cnt_reg == DW'(CLK_DIV - 1)) begin
      div_cnt_reg <= '0;
      sd_clk      <= ~sd_clk;
    end else begin
      div_cnt_reg <= div_cnt_reg + DW'(1);
    end
  end

  // Word assembly: nibble k lands at bit 8*(k/2) + (k even ? 4 : 0)
  logic [23:0] tick_cnt_reg;
  logic [9:0]  word_left_reg;
  logic [2:0]  nib_idx_reg;
  logic [3:0]  crc_cnt_reg;
  logic [31:0] word_asm_reg, word_ins, push_data_reg;
  logic        push_reg;
  logic [4:0]  nib_off;
  assign nib_off = {nib_idx_reg[2:1], ~nib_idx_reg[0], 2'b00};

  always_comb begin
    word_ins = word_asm_reg;
    word_ins[nib_off +: 4] = dat_s2_reg;
  end

`ifdef SD_DAT_RX_CRC_EN
  logic [15:0] crc_reg  [4];
  logic [15:0] crc_next [4];
  logic [3:0]  crc_msb;
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_crc
      logic fb;
      assign fb           = crc_reg[gi][15] ^ dat_s2_reg[gi];
      assign crc_next[gi] = {crc_reg[gi][14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      assign crc_msb[gi]  = crc_reg[gi][15];
    end
  endgenerate
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= S_IDLE;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      crc_err_reg     <= 1'b0;
      timeout_reg     <= 1'b0;
      irq_en_reg      <= 1'b0;
      blklen_cfg_reg  <= 12'd512;
      timeout_cfg_reg <= 24'hFFFFFF;
      tick_cnt_reg    <= '0;
      word_left_reg   <= '0;
      nib_idx_reg     <= '0;
      crc_cnt_reg     <= '0;
      word_asm_reg    <= '0;
      push_data_reg   <= '0;
      push_reg        <= 1'b0;
`ifdef SD_DAT_RX_CRC_EN
      for (int i = 0; i < 4; i++) crc_reg[i] <= '0;
`endif
    end else begin
      push_reg <= 1'b0;
      if (wr_en && address == 2'd2) blklen_cfg_reg <= {writedata[11:2], 2'b00};
      if (wr_en && address == 2'd3) timeout_cfg_reg <= writedata[23:0];
      if (ctrl_wr) irq_en_reg <= writedata[1];

      case (state_reg)
        S_IDLE: begin
          if (start_req) begin
            state_reg     <= S_WAIT_START;
            busy_reg      <= 1'b1;
            done_reg      <= 1'b0;
            tick_cnt_reg  <= timeout_cfg_reg;
            word_left_reg <= blklen_cfg_reg[11:2];
            nib_idx_reg   <= '0;
            crc_cnt_reg   <= '0;
`ifdef SD_DAT_RX_CRC_EN
            for (int i = 0; i < 4; i++) crc_reg[i] <= '0;
`endif
          end
        end
        S_WAIT_START: begin
          if (tick) begin
            if (dat_s2_reg == 4'h0) begin
              state_reg <= S_DATA;
            end else if (tick_cnt_reg <= 24'd1) begin
              // The tick that would bring the counter to zero expires the wait
              timeout_reg <= 1'b1;
              state_reg   <= S_DONE;
            end else begin
              tick_cnt_reg <= tick_cnt_reg - 24'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            word_asm_reg <= word_ins;
            nib_idx_reg  <= nib_idx_reg + 3'd1;
`ifdef SD_DAT_RX_CRC_EN
            for (int i = 0; i < 4; i++) crc_reg[i] <= crc_next[i];
`endif
            if (nib_idx_reg == 3'd7) begin
              push_reg      <= 1'b1;
              push_data_reg <= word_ins;
              word_left_reg <= word_left_reg - 10'd1;
              if (word_left_reg == 10'd1) state_reg <= S_CRC;
            end
          end
        end
        S_CRC: begin
          if (tick) begin
`ifdef SD_DAT_RX_CRC_EN
            if ((dat_s2_reg ^ crc_msb) != 4'h0) crc_err_reg <= 1'b1;
            for (int i = 0; i < 4; i++) crc_reg[i] <= {crc_reg[i][14:0], 1'b0};
`endif
            crc_cnt_reg <= crc_cnt_reg + 4'd1;
            if (crc_cnt_reg == 4'd15) state_reg <= S_END;
          end
        end
        S_END: begin
          if (tick) begin
            if (dat_s2_reg != 4'hF) crc_err_reg <= 1'b1;
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase

      // Flush clears the sticky flags; while a block is running it also aborts it
      if (flush_req) begin
        done_reg    <= 1'b0;
        crc_err_reg <= 1'b0;
        timeout_reg <= 1'b0;
        if (state_reg != S_IDLE) begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          push_reg  <= 1'b0;
        end
      end
    end
  end

  // Receive FIFO; pointers carry one extra bit so full and empty differ
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] level;
  logic full, empty, pop, push_ok;
  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign pop     = pop_req & ~empty;
  assign push_ok = push_reg & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= push_data_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      overrun_reg <= 1'b0;
    end else if (flush_req) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (push_reg && !push_ok) overrun_reg <= 1'b1;
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Read data is registered from the address decode every cycle
  logic [31:0] status;
  assign status = {8'h00, 16'(level), 2'b00, irq_en_reg, overrun_reg,
                   timeout_reg, crc_err_reg, done_reg, busy_reg};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        2'd0:    readdata <= empty ? 32'd0 : mem[rd_ptr_reg[AW-1:0]];
        2'd1:    readdata <= status;
        2'd2:    readdata <= {20'd0, blklen_cfg_reg};
        default: readdata <= {8'd0, timeout_cfg_reg};
      endcase
    end
  end

  assign irq = done_reg & irq_en_reg;

endmodule

// File: doc/sd_dat_block_rx.md
# sd_dat_block_rx

Hardware receiver for SD-card 4-bit data blocks, the card-to-host direction of the SD DAT bus that software otherwise bit-bangs through the SD data PIO. It generates the SD clock, detects the start bit on DAT[3:0], assembles nibbles into 32-bit words, checks the per-line CRC16, and buffers the block in a FIFO. The CPU drains the FIFO over an Avalon-MM slave port. The SD command path and the card-side transmitter are outside this block.

## Interface
- CLK_DIV, 4: half-period of sd_clk in clk cycles; legal range ≥2.
- FIFO_DEPTH, 128: receive FIFO depth in 32-bit words, power of two.
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select: 0 DATA, 1 CTRL/STATUS, 2 BLKLEN, 3 TIMEOUT.
- chipselect  in  1  slave select.
- read  in  1  read strobe; pops the FIFO at address 0.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- sd_clk  out  1  SD clock to the card.
- dat_in  in  4  SD DAT[3:0], asynchronous to clk.
- irq  out  1  level interrupt = done & irq_en.

## Operation
- dat_in passes through a 2-FF synchronizer. A sample is taken on the clk cycle in which sd_clk is driven 0→1, the "tick".
- sd_clk toggles every CLK_DIV clk cycles while busy=1 and stays low otherwise.
- BLKLEN[11:0] is the block length in bytes. Default 512. Legal values are multiples of 4 from 4 to 2048; the low 2 bits are ignored.
- TIMEOUT[23:0] is the number of ticks to wait for the start bit. Default 0xFFFFFF.
- CTRL write (address 1):
  - bit0 start: begins a block only when idle.
  - bit1 irq_en: persistent.
  - bit2 flush: empties the FIFO and clears done/crc_err/timeout/overrun.
- STATUS read (address 1):
  - bit0 busy, bit1 done, bit2 crc_err, bit3 timeout, bit4 overrun, bit5 irq_en.
  - [23:8] FIFO level in words.
- FSM states and transitions:
  - IDLE: start → WAIT_START; the tick counter loads TIMEOUT.
  - WAIT_START: a tick with all four DAT lines 0 → DATA. Counter reaching 0 → set timeout → DONE.
  - DATA: 2 nibbles per byte, high nibble first. Byte n of the word lands in bits [8n+7:8n]. The word is pushed after its 8th nibble. After BLKLEN×2 nibbles → CRC.
  - CRC: 16 ticks. Each line's CRC bit is shifted MSB first.
  - END: one tick, all lines must be 1; otherwise set crc_err. → DONE.
  - DONE: set done, clear busy → IDLE.
- CRC: one CRC16-CCITT per line (x^16+x^12+x^5+1), initialized to 0, computed over that line's data bits only. Any mismatch sets crc_err.
- FIFO full when a word completes: the word is dropped, overrun is set, and reception continues.
- A DATA read (address 0) with read=1 pops one word. Reading an empty FIFO returns 0 and does not pop.
- A start written while busy is ignored. A flush written while busy aborts the block and returns to IDLE.
- BLKLEN and TIMEOUT writes while busy take effect on the next start.

## Timing
- Reset values:
  - readdata=0, sd_clk=0, irq=0.
  - FSM=IDLE, FIFO empty, all flags 0.
  - BLKLEN=512, TIMEOUT=0xFFFFFF.
- Reset applied mid-block aborts immediately to these values.
- Read latency is 1 clk. readdata is registered from the address decode every cycle. A pop updates the FIFO read pointer in the same edge that captures readdata.
- Latency from sample to STATUS/FIFO is 3 clk: 2 synchronizer stages plus 1 register.
- One tick every 2×CLK_DIV clk cycles.
- A simultaneous FIFO push and pop keeps the level unchanged.
- done/crc_err/timeout/overrun are sticky until flush or reset. A new start clears done only.

## Configuration
- SD_DAT_RX_CRC_EN defined:
  - CRC generators are instantiated.
  - crc_err reflects CRC and end-bit checks.
- SD_DAT_RX_CRC_EN undefined:
  - No CRC logic.
  - The 16 CRC ticks are still consumed.
  - Only end-bit errors set crc_err.

## Test plan
- Reset, then read STATUS and BLKLEN → 0x00000000 and 0x200; sd_clk stays low.
- BLKLEN=8, start, card sends bytes 0x01..0x08 with correct CRC and end bit:
  - FIFO level=2.
  - Pops return 0x04030201, then 0x08070605.
  - STATUS = done=1, crc_err=0; irq follows irq_en.
- Same block with one CRC bit flipped on DAT2 → crc_err=1, done=1, data still delivered. With the macro undefined → crc_err=0.
- TIMEOUT=10, start, DAT held 0xF → timeout=1, done=1 after 10 ticks; FIFO level=0.
- FIFO_DEPTH=4, BLKLEN=24, no pops → level=4, overrun=1, done=1. Flush → level=0, flags clear.
- Assert reset_n low during DATA → all outputs return to reset values. The next start receives a full block correctly.
